// File: rtl/cpu.sv
// cpu: single-cycle RV32I core (clk, reset only); imem/dmem/rf state observable hierarchically
module cpu_mem #(
  parameter int WORDS = 256
) (
  input  logic                     clk_i,
  input  logic                     we_i,
  input  logic [$clog2(WORDS)-1:0] addr_i,
  input  logic [31:0]              wdata_i,
  output logic [31:0]              rdata_o
);
  logic [31:0] memory [0:WORDS-1];
  always_ff @(posedge clk_i) if (we_i) memory[addr_i] <= wdata_i;
  assign rdata_o = memory[addr_i];
  task print_memory;
    for (int k = 0; k < WORDS; k++) $display("%0d: %h", k, memory[k]);
  endtask
endmodule

module cpu_rf (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        we_i,
  input  logic [4:0]  rs1_i,
  input  logic [4:0]  rs2_i,
  input  logic [4:0]  rd_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] rs1_o,
  output logic [31:0] rs2_o
);
  logic [31:0] regs [0:31];
  always_ff @(posedge clk_i)
    if (rst_i) for (int k = 0; k < 32; k++) regs[k] <= '0;
    else if (we_i && rd_i != 5'd0) regs[rd_i] <= wdata_i;
  assign rs1_o = rs1_i == 5'd0 ? '0 : regs[rs1_i];
  assign rs2_o = rs2_i == 5'd0 ? '0 : regs[rs2_i];
  task print_registers;
    for (int k = 0; k < 32; k++) $display("x%0d = %h", k, regs[k]);
  endtask
endmodule

module cpu #(
  parameter int          IMEM_WORDS = 256,
  parameter int          DMEM_WORDS = 256,
  parameter logic [31:0] RESET_PC   = 32'h0000_0000
) (
  input logic clk,
  input logic reset
);
  localparam int IA = $clog2(IMEM_WORDS);
  localparam int DA = $clog2(DMEM_WORDS);
  logic [31:0] pc_q, pc_d, instr, rs1_v, rs2_v, rd_v, alu_b, alu_y, addr, rdata;
  logic [31:0] imm_i, imm_s, imm_b, imm_j, imm_u;
  logic [6:0] op, f7;
  logic [2:0] f3;
  logic rf_we, dm_we, alt, r_ok, i_ok, taken, unused_bits;
  assign op = instr[6:0];
  assign f3 = instr[14:12];
  assign f7 = instr[31:25];
  assign imm_i = {{20{instr[31]}}, instr[31:20]};
  assign imm_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
  assign imm_b = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
  assign imm_j = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
  assign imm_u = {instr[31:12], 12'b0};
  cpu_mem #(.WORDS(IMEM_WORDS)) imem (
    .clk_i(clk), .we_i(1'b0), .addr_i(pc_q[IA+1:2]), .wdata_i(32'b0), .rdata_o(instr)
  );
  cpu_rf rf (
    .clk_i(clk), .rst_i(reset), .we_i(rf_we & ~reset), .rs1_i(instr[19:15]), .rs2_i(instr[24:20]),
    .rd_i(instr[11:7]), .wdata_i(rd_v), .rs1_o(rs1_v), .rs2_o(rs2_v)
  );
  cpu_mem #(.WORDS(DMEM_WORDS)) dmem (
    .clk_i(clk), .we_i(dm_we & ~reset), .addr_i(addr[DA+1:2]), .wdata_i(rs2_v), .rdata_o(rdata)
  );
  assign addr = rs1_v + (op == 7'h23 ? imm_s : imm_i);
  assign unused_bits = ^{addr[31:DA+2], addr[1:0]};
  assign alu_b = op == 7'h33 ? rs2_v : imm_i;
  // For I-type only shifts-right carry the arithmetic flag; elsewhere bit 30 is immediate data
  assign alt = op == 7'h33 ? f7[5] : (f3 == 3'd5 && f7[5]);
  assign r_ok = f7 == 7'h00 || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5));
  assign i_ok = (f3 != 3'd1 && f3 != 3'd5) || f7 == 7'h00 || (f3 == 3'd5 && f7 == 7'h20);
  // BEQ/BNE/BLT/BGE: f3[2] picks signed-less-than vs equality, f3[0] inverts
  assign taken = !f3[1] && (f3[2] ? (($signed(rs1_v) < $signed(rs2_v)) ^ f3[0]) : ((rs1_v == rs2_v) ^ f3[0]));
  always_comb begin
    alu_y = '0;
    case (f3)
      3'd0: alu_y = alt ? rs1_v - alu_b : rs1_v + alu_b;
      3'd1: alu_y = rs1_v << alu_b[4:0];
      3'd2: alu_y = {31'b0, $signed(rs1_v) < $signed(alu_b)};
      3'd3: alu_y = {31'b0, rs1_v < alu_b};
      3'd4: alu_y = rs1_v ^ alu_b;
      3'd5: alu_y = alt ? $unsigned($signed(rs1_v) >>> alu_b[4:0]) : rs1_v >> alu_b[4:0];
      3'd6: alu_y = rs1_v | alu_b;
      default: alu_y = rs1_v & alu_b;
    endcase
  end
  always_comb begin
    pc_d = pc_q + 32'd4;
    rd_v = alu_y;
    rf_we = 1'b0;
    dm_we = 1'b0;
    case (op)
      7'h33: rf_we = r_ok;
      7'h13: rf_we = i_ok;
      7'h03: begin
        rf_we = f3 == 3'd2;
        rd_v = rdata;
      end
      7'h23: dm_we = f3 == 3'd2;
      7'h63: pc_d = taken ? pc_q + imm_b : pc_q + 32'd4;
      7'h6F: begin
        rf_we = 1'b1;
        rd_v = pc_q + 32'd4;
        pc_d = pc_q + imm_j;
      end
      7'h67: if (f3 == 3'd0) begin
        rf_we = 1'b1;
        rd_v = pc_q + 32'd4;
        pc_d = (rs1_v + imm_i) & ~32'd1;
      end
      7'h37: begin
        rf_we = 1'b1;
        rd_v = imm_u;
      end
      7'h17: begin
        rf_we = 1'b1;
        rd_v = pc_q + imm_u;
      end
      default: ;
    endcase
  end
  always_ff @(posedge clk) pc_q <= reset ? RESET_PC : pc_d;
endmodule

// File: tb/tb_cpu.sv
// tb_cpu: directed-program checks of the cpu core through hierarchical state
module tb_cpu;
  logic clk = 1'b0, reset = 1'b1;
  int n = 0, fails = 0;
  cpu dut (.clk(clk), .reset(reset));
  always #5 clk = ~clk;
  function automatic logic [31:0] er(int f7, int rs2, int rs1, int f3, int rd);
    return {7'(f7), 5'(rs2), 5'(rs1), 3'(f3), 5'(rd), 7'h33};
  endfunction
  function automatic logic [31:0] ei(int imm, int rs1, int f3, int rd, logic [6:0] op);
    logic [31:0] m = imm;
    return {m[11:0], 5'(rs1), 3'(f3), 5'(rd), op};
  endfunction
  function automatic logic [31:0] es(int imm, int rs2, int rs1);
    logic [31:0] m = imm;
    return {m[11:5], 5'(rs2), 5'(rs1), 3'd2, m[4:0], 7'h23};
  endfunction
  function automatic logic [31:0] eb(int imm, int rs2, int rs1, int f3);
    logic [31:0] m = imm;
    return {m[12], m[10:5], 5'(rs2), 5'(rs1), 3'(f3), m[4:1], m[11], 7'h63};
  endfunction
  function automatic logic [31:0] ej(int imm, int rd);
    logic [31:0] m = imm;
    return {m[20], m[10:1], m[11], m[19:12], 5'(rd), 7'h6F};
  endfunction
  function automatic logic [31:0] eu(int imm20, int rd, logic [6:0] op);
    logic [31:0] m = imm20;
    return {m[19:0], 5'(rd), op};
  endfunction
  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic hold();
    reset = 1'b1;
    for (int k = 0; k < 256; k++) dut.imem.memory[k] = 32'h0;
  endtask
  task automatic go();
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask
  task automatic run(int c);
    repeat (c) @(posedge clk);
    #1;
  endtask
  initial begin
    logic any;
    for (int k = 0; k < 256; k++) dut.dmem.memory[k] = 32'h0;
    hold();
    dut.imem.memory[0] = ei(5, 0, 0, 1, 7'h13);
    dut.imem.memory[1] = ei(7, 0, 0, 2, 7'h13);
    dut.imem.memory[2] = er(0, 2, 1, 0, 3);
    dut.imem.memory[3] = er(32, 1, 2, 0, 4);
    go();
    chk("reset_pc", dut.pc_q, 32'h0);
    chk("reset_x1", dut.rf.regs[1], 32'h0);
    run(4);
    chk("add_x1", dut.rf.regs[1], 32'd5);
    chk("add_x2", dut.rf.regs[2], 32'd7);
    chk("add_x3", dut.rf.regs[3], 32'd12);
    chk("sub_x4", dut.rf.regs[4], 32'd2);
    hold();
    dut.dmem.memory[0] = 32'hDEADBEEF;
    dut.imem.memory[0] = ei(0, 0, 2, 5, 7'h03);
    dut.imem.memory[1] = es(8, 5, 0);
    go();
    run(2);
    chk("lw_x5", dut.rf.regs[5], 32'hDEADBEEF);
    chk("sw_dmem2", dut.dmem.memory[2], 32'hDEADBEEF);
    chk("sw_dmem0", dut.dmem.memory[0], 32'hDEADBEEF);
    hold();
    dut.imem.memory[0] = ei(3, 0, 0, 1, 7'h13);
    dut.imem.memory[1] = eb(8, 1, 1, 0);
    dut.imem.memory[2] = ei(1, 0, 0, 2, 7'h13);
    dut.imem.memory[3] = ei(9, 0, 0, 3, 7'h13);
    go();
    run(3);
    chk("beq_x2", dut.rf.regs[2], 32'h0);
    chk("beq_x3", dut.rf.regs[3], 32'd9);
    chk("beq_pc", dut.pc_q, 32'd16);
    hold();
    dut.imem.memory[0] = ej(8, 1);
    dut.imem.memory[2] = ei(5, 0, 0, 0, 7'h13);
    go();
    run(1);
    chk("jal_x1", dut.rf.regs[1], 32'd4);
    chk("jal_pc", dut.pc_q, 32'd8);
    run(1);
    chk("x0_zero", dut.rf.regs[0], 32'h0);
    chk("x0_pc", dut.pc_q, 32'd12);
    hold();
    dut.imem.memory[0] = ei(-1, 0, 0, 1, 7'h13);
    dut.imem.memory[1] = ei('h404, 1, 5, 2, 7'h13);
    dut.imem.memory[2] = ei(28, 1, 5, 3, 7'h13);
    dut.imem.memory[3] = er(0, 1, 0, 3, 4);
    go();
    run(4);
    chk("srai_x2", dut.rf.regs[2], 32'hFFFFFFFF);
    chk("srli_x3", dut.rf.regs[3], 32'h0000000F);
    chk("sltu_x4", dut.rf.regs[4], 32'd1);
    hold();
    dut.imem.memory[0] = eu('h12345, 1, 7'h37);
    dut.imem.memory[1] = eu(1, 2, 7'h17);
    dut.imem.memory[3] = ei(-8, 0, 0, 3, 7'h13);
    dut.imem.memory[4] = er(0, 0, 3, 2, 4);
    dut.imem.memory[5] = er(0, 4, 4, 1, 5);
    dut.imem.memory[6] = ei(36, 0, 0, 6, 7'h67);
    dut.imem.memory[7] = ei(1, 0, 0, 7, 7'h13);
    dut.imem.memory[8] = ei(2, 0, 0, 7, 7'h13);
    dut.imem.memory[9] = eb(8, 0, 0, 1);
    dut.imem.memory[10] = er(0, 3, 1, 4, 8);
    dut.imem.memory[11] = es(3, 3, 0);
    go();
    run(10);
    chk("lui_x1", dut.rf.regs[1], 32'h12345000);
    chk("auipc_x2", dut.rf.regs[2], 32'h00001004);
    chk("addi_neg_x3", dut.rf.regs[3], 32'hFFFFFFF8);
    chk("slt_x4", dut.rf.regs[4], 32'd1);
    chk("sll_x5", dut.rf.regs[5], 32'd2);
    chk("jalr_x6", dut.rf.regs[6], 32'd28);
    chk("jalr_skip_x7", dut.rf.regs[7], 32'h0);
    chk("xor_x8", dut.rf.regs[8], 32'hEDCBAFF8);
    chk("sw_misaligned", dut.dmem.memory[0], 32'hFFFFFFF8);
    chk("mixed_pc", dut.pc_q, 32'd48);
    hold();
    dut.imem.memory[0] = ei(10, 0, 0, 1, 7'h13);
    dut.imem.memory[1] = ei(1, 1, 0, 1, 7'h13);
    dut.imem.memory[2] = es(0, 1, 0);
    dut.imem.memory[3] = ej(-8, 0);
    go();
    run(11);
    chk("loop_x1", dut.rf.regs[1], 32'd14);
    chk("loop_pc", dut.pc_q, 32'd8);
    chk("loop_dmem0", dut.dmem.memory[0], 32'd13);
    reset = 1'b1;
    run(1);
    chk("midreset_pc", dut.pc_q, 32'h0);
    any = 1'b0;
    for (int k = 0; k < 32; k++) any |= |dut.rf.regs[k];
    chk("midreset_regs", {31'b0, any}, 32'h0);
    chk("midreset_sw_abort", dut.dmem.memory[0], 32'd13);
    reset = 1'b0;
    run(50);
    chk("rerun_x1", dut.rf.regs[1], 32'd27);
    chk("rerun_dmem0", dut.dmem.memory[0], 32'd26);
    chk("rerun_pc", dut.pc_q, 32'd8);
    dut.rf.print_registers();
    dut.dmem.print_memory();
    $display("End of test - %0d assertions evaluated, %0d failures", n, fails);
    $finish;
  end
endmodule
